// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode map, sequencer
// states, instruction classes and the control-strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11010;

  // T0..T7 are consecutive so the sequencer can step by increment.
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t S_RESET = 4'd0;
  localparam state_t S_T0    = 4'd1;
  localparam state_t S_T1    = 4'd2;
  localparam state_t S_T2    = 4'd3;
  localparam state_t S_T3    = 4'd4;
  localparam state_t S_T4    = 4'd5;
  localparam state_t S_T5    = 4'd6;
  localparam state_t S_T6    = 4'd7;
  localparam state_t S_T7    = 4'd8;
  localparam state_t S_HALT  = 4'd9;

  typedef enum logic [3:0] {
    CL_NOP, CL_RALU, CL_IALU, CL_LDI, CL_UNARY, CL_MULDIV, CL_LD, CL_ST,
    CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in, inc_pc;
    logic gra, grb, grc, r_in, r_out;
    logic mem_read, mem_write, mem_en;
    logic [OPCODE_W-1:0] alu_op;
    logic run;
  } ctrl_t;

  // Final cycle of each instruction class; the boundary where stop is sampled.
  function automatic state_t last_step(input iclass_t c);
    state_t s;
    case (c)
      CL_RALU, CL_IALU, CL_LDI:                   s = S_T5;
      CL_UNARY:                                   s = S_T4;
      CL_MULDIV, CL_BR:                           s = S_T6;
      CL_LD, CL_ST:                               s = S_T7;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO:     s = S_T3;
      default:                                    s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit bundle between IR/CON FF and the datapath strobes.
// mem_ready exists only when CTRL_MEM_WAIT_EN is defined.
interface control_sequencer_if #(parameter int unsigned DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] IR;
  logic con_ff_bit, stop;
`ifdef CTRL_MEM_WAIT_EN
  logic mem_ready;
`endif
  logic PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout, BAout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in, IncPC;
  logic Gra, Grb, Grc, Rin, Rout;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic [4:0] opcode;
  logic run;

  modport master (
`ifdef CTRL_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  IR, con_ff_bit, stop,
    output PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout, BAout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in, IncPC,
    output Gra, Grb, Grc, Rin, Rout, Mem_Read, Mem_Write, Mem_enable512x32,
    output opcode, run
  );

  modport slave (
`ifdef CTRL_MEM_WAIT_EN
    output mem_ready,
`endif
    output IR, con_ff_bit, stop,
    input  PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout, BAout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, Mem_Read, Mem_Write, Mem_enable512x32,
    input  opcode, run
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decode: IR opcode field to instruction class and ALU function.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] op_i,
  output iclass_t             cls_o,
  output logic [OPCODE_W-1:0] alu_op_o
);

  always_comb begin
    cls_o    = CL_NOP;
    alu_op_o = '0;
    case (op_i)
      OP_LD:   begin cls_o = CL_LD;  alu_op_o = OP_ADD; end
      OP_LDI:  begin cls_o = CL_LDI; alu_op_o = OP_ADD; end
      OP_ST:   begin cls_o = CL_ST;  alu_op_o = OP_ADD; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL:
               begin cls_o = CL_RALU; alu_op_o = op_i; end
      // Immediate forms reuse the register-register ALU function.
      OP_ADDI: begin cls_o = CL_IALU; alu_op_o = OP_ADD; end
      OP_ANDI: begin cls_o = CL_IALU; alu_op_o = OP_AND; end
      OP_ORI:  begin cls_o = CL_IALU; alu_op_o = OP_OR;  end
      OP_MUL, OP_DIV: begin cls_o = CL_MULDIV; alu_op_o = op_i; end
      OP_NEG, OP_NOT: begin cls_o = CL_UNARY;  alu_op_o = op_i; end
      OP_BR:   begin cls_o = CL_BR;  alu_op_o = OP_ADD; end
      OP_JR:   cls_o = CL_JR;
      OP_IN:   cls_o = CL_IN;
      OP_OUT:  cls_o = CL_OUT;
      OP_MFHI: cls_o = CL_MFHI;
      OP_MFLO: cls_o = CL_MFLO;
      OP_HALT: cls_o = CL_HALT;
      default: cls_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the datapath strobes.
// Define CTRL_MEM_WAIT_EN to stall memory cycles on mem_ready.
module control_sequencer
  import cpu_pkg::*;
#(parameter int unsigned DATA_WIDTH = 32)
(
  input logic Clock,
  input logic clear,
  control_sequencer_if.master bus
);

  state_t  state_q, state_d;
  logic    halted_q, halted_d;
  logic    con_q, con_d;
  iclass_t cls;
  logic [OPCODE_W-1:0] alu_op;
  logic    mem_ok, stall;
  ctrl_t   ctl;
  logic    ir_unused;

  assign ir_unused = ^bus.IR[DATA_WIDTH-OPCODE_W-1:0];

  opcode_decoder u_dec (
    .op_i    (bus.IR[DATA_WIDTH-1 -: OPCODE_W]),
    .cls_o   (cls),
    .alu_op_o(alu_op)
  );

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign stall = !mem_ok && ((state_q == S_T1) ||
                             (cls == CL_LD && state_q == S_T6) ||
                             (cls == CL_ST && state_q == S_T7));

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q  <= S_RESET;
      halted_q <= 1'b0;
      con_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      con_q    <= con_d;
    end
  end

  // Next state: step through T-states, branch back at the class's last cycle.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    con_d    = con_q;
    if (state_q == S_T3 && cls == CL_BR) con_d = bus.con_ff_bit;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  if (!bus.stop && !halted_q) state_d = S_T0;
      default: begin
        if (!stall) begin
          if (state_q == S_T2 && cls == CL_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (state_q == last_step(cls)) begin
            state_d = bus.stop ? S_HALT : S_T0;
          end else begin
            state_d = state_t'(state_q + STATE_W'(1));
          end
        end
      end
    endcase
  end

  // Strobe decode from registered state and current instruction class.
  always_comb begin
    ctl     = '0;
    ctl.run = (state_q >= S_T0) && (state_q <= S_T7);
    case (state_q)
      S_T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = OP_ADD; end
      S_T1: begin ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.mem_read = 1'b1; ctl.mem_en = 1'b1; ctl.mdr_in = 1'b1; end
      S_T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
      S_T3: case (cls)
        CL_RALU, CL_IALU: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
        CL_LDI, CL_LD, CL_ST: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
        CL_UNARY:  begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_op; end
        CL_MULDIV: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
        CL_BR:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; end
        CL_JR:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
        CL_IN:     begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        CL_OUT:    begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
        CL_MFHI:   begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        CL_MFLO:   begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        CL_RALU:   begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_op; end
        CL_IALU, CL_LDI, CL_LD, CL_ST: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_op; end
        CL_UNARY:  begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        CL_MULDIV: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_op; end
        CL_BR:     begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        CL_RALU, CL_IALU, CL_LDI: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        CL_MULDIV:    begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
        CL_LD, CL_ST: begin ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1; end
        CL_BR:        begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_op; end
        default: ;
      endcase
      S_T6: case (cls)
        CL_MULDIV: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
        CL_LD:     begin ctl.mem_read = 1'b1; ctl.mem_en = 1'b1; ctl.mdr_in = 1'b1; end
        CL_ST:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
        CL_BR:     begin ctl.zlo_out = 1'b1; ctl.pc_in = con_q; end
        default: ;
      endcase
      S_T7: case (cls)
        CL_LD:   begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
        CL_ST:   begin ctl.mem_write = 1'b1; ctl.mem_en = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end

  assign {bus.PCout, bus.Zhi_out, bus.Zlo_out, bus.MDRout, bus.HIout, bus.LOout,
          bus.Inport_out, bus.Cout, bus.BAout, bus.MARin, bus.Zin, bus.PCin,
          bus.MDRin, bus.IRin, bus.Yin, bus.HIin, bus.LOin, bus.outport_in,
          bus.IncPC, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Mem_Read,
          bus.Mem_Write, bus.Mem_enable512x32, bus.opcode, bus.run} = ctl;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus-based CPU datapath. It decodes the 5-bit opcode in IR[31:27] and steps through the fetch cycles T0–T2, then the execute cycles T3–T7, driving every datapath strobe the `System` top level exposes: register-out, register-in, select/encode, ALU opcode and memory controls. It replaces the hand-written control sequences in the system testbenches and sits between `IR`/`con_ff_bit` and the datapath control inputs.

## Interface
- `DATA_WIDTH`, 32, IR width.
- `Clock` in 1: single clock; all state changes on posedge.
- `clear` in 1: synchronous reset, active-low.
- `IR` in 32: instruction register contents; opcode is IR[31:27].
- `con_ff_bit` in 1: branch condition from the CON FF.
- `stop` in 1: external pause request, honoured at instruction boundaries.
- `mem_ready` in 1: memory completion. Present only with `CTRL_MEM_WAIT_EN`.
- `PCout`, `Zhi_out`, `Zlo_out`, `MDRout`, `HIout`, `LOout`, `Inport_out`, `Cout`, `BAout` out 1 each: bus drivers, at most one asserted per cycle.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`, `outport_in`, `IncPC` out 1 each: register loads.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout` out 1 each: register-file select/encode.
- `Mem_Read`, `Mem_Write`, `Mem_enable512x32` out 1 each: memory control.
- `opcode` out 5: ALU function.
- `run` out 1: high while executing; low in RESET and HALT.

## Operation
- Opcode map, used both for IR decode and as ALU function codes:
  - 00000 ld, 00001 ldi, 00010 st
  - 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol
  - 01011 addi, 01100 andi, 01101 ori
  - 01110 mul, 01111 div, 10000 neg, 10001 not
  - 10010 br, 10011 jr, 10101 in, 10110 out, 10111 mfhi, 11000 mflo, 11001 nop, 11010 halt
  - Any unlisted code executes as nop.
- Immediate ALU ops drive the matching register-register code on `opcode` (addi→00011, andi→00101, ori→00110).
- Fetch, every instruction:
  - T0: PCout, MARin, IncPC, Zin, opcode=add.
  - T1: Zlo_out, PCin, Mem_Read, Mem_enable512x32, MDRin.
  - T2: MDRout, IRin.
- Execute, per class:
  - R-ALU: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,opcode; T5 Zlo_out,Gra,Rin.
  - I-ALU: T3 Grb,Rout,Yin; T4 Cout,Zin,opcode; T5 Zlo_out,Gra,Rin.
  - ldi: same as I-ALU, but T3 uses BAout instead of Rout and opcode=add.
  - neg/not: T3 Grb,Rout,Zin,opcode; T4 Zlo_out,Gra,Rin.
  - mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,opcode; T5 Zlo_out,LOin; T6 Zhi_out,HIin.
  - ld: T3 Grb,BAout,Yin; T4 Cout,Zin,add; T5 Zlo_out,MARin; T6 Mem_Read,Mem_enable512x32,MDRin; T7 MDRout,Gra,Rin.
  - st: T3–T5 as ld; T6 Gra,Rout,MDRin; T7 Mem_Write,Mem_enable512x32.
  - br: T3 Gra,Rout, and `con_ff_bit` is captured into internal `con_q` at the end of T3; T4 PCout,Yin; T5 Cout,Zin,add; T6 Zlo_out with PCin only if `con_q`.
  - jr: T3 Gra,Rout,PCin.
  - in: T3 Inport_out,Gra,Rin.
  - out: T3 Gra,Rout,outport_in.
  - mfhi / mflo: T3 HIout (or LOout),Gra,Rin.
  - nop: no execute cycles.
- States: RESET, T0–T7, HALT.
- After an instruction's last cycle: go to T0, or to HALT if `stop`=1 at that edge.
- halt opcode: enters HALT from T2 and sets sticky `halted`.
- HALT exits to T0 when `stop`=0 and `halted`=0; otherwise it holds. `halted` clears only on reset.

## Timing
- Moore machine: outputs decode from the registered state plus IR, and are stable for the whole cycle.
- `clear`=0 at a posedge puts the state in RESET from any state, including mid-instruction; RESET aborts the instruction with no partial write-back.
- In RESET, all outputs are 0, `opcode`=0 and `run`=0. The first posedge with `clear`=1 moves RESET→T0.
- Latency: register-register ALU = 6 cycles, mul/div = 7, ld/st = 8, mfhi = 4, nop = 3.
- `stop` is sampled only at instruction boundaries; asserting it mid-instruction never truncates the instruction.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - Adds port `mem_ready`.
  - Fetch T1 and ld T6 hold all their strobes until a posedge with `mem_ready`=1. Repeated PCin reloads the same Z value.
  - st T7 likewise holds until `mem_ready`=1.
- Not defined: no `mem_ready` port; every memory access takes exactly one cycle.

## Structure
- Shared package `cpu_pkg` holds the opcode localparams, the state enum and the instruction-class enum.
- One sub-module, `opcode_decoder`: combinational IR[31:27] → {class, alu_op}.

## Test plan
- Reset, then add R1,R2,R3 (IR 0x18918000): T0–T5 strobes exactly as listed; `opcode`=00011 in T4; T5 has Zlo_out, Gra and Rin.
- addi (opcode 01011): T4 shows Cout=1, Grc=0 and `opcode`=00011.
- mul: LOin in T5, HIin in T6, return to T0 after 7 cycles.
- br with `con_ff_bit`=0 at end of T3: PCin=0 in T6. Repeat with `con_ff_bit`=1: PCin=1 in T6.
- halt: `run`=0 from the cycle after T2, and HALT persists when `stop`=0. Apply `clear`=0 for 1 cycle: RESET, then T0 with `run`=1.
- `clear`=0 during ld T6: next cycle all strobes are 0 and no MDRout/Rin ever occurs. With `CTRL_MEM_WAIT_EN`, `mem_ready` low for 3 cycles in fetch T1 holds Mem_Read for 4 cycles.
